lsu_align_unit: RTL and testbench
=================================

Name: lsu_align_unit

Overview:
Load/store alignment stage between the core's execute/memory stage and the word-organised data memory.
- Turns byte-addressed RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word accesses with active-low chip-select and write strobes plus byte masks.
- Sign- or zero-extends load data.
- Splits misaligned accesses into two consecutive word accesses, stalling the core for one cycle.

Parameters:
ADDR_W, 21, word-address width driven to the data memory; word address = req_addr[ADDR_W+1:2]

Ports:
clk  in  1  core clock, rising-edge state updates
rst  in  1  synchronous active-high reset
req_valid  in  1  load/store request this cycle
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 size/sign encoding
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
stall  out  1  hold pipeline; core keeps request stable
done  out  1  access completes this cycle
ld_data  out  32  extended load result, valid when done=1 and load
mem_cs  out  1  memory chip select, active low
mem_wr  out  1  0 = write, 1 = read
mem_mask  out  4  byte write enables
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  byte-lane-positioned write data
mem_rdata  in  32  asynchronous read data from memory

Behaviour:
- One clock `clk`; reset `rst` is synchronous and active-high. The memory writes on the falling clock edge and reads combinationally.
- States: IDLE and SECOND.

Reset and idle outputs:
- While rst=1 and after reset: state=IDLE, internal registers 0, stall=0, done=0, ld_data=0, mem_cs=1, mem_wr=1, mem_mask=0, mem_addr=0, mem_wdata=0.
- When no access is in progress: mem_cs=1, mem_wr=1, mem_mask=0.

Size and offset:
- Byte offset o = req_addr[1:0]; base mask is 0001 (B), 0011 (H) or 1111 (W).
- Misaligned: H with o=3, or W with o≠0.
- Illegal funct3 (011, 110, 111; also 100/101 when store): no memory access, done=1, ld_data=0, stall=0.

IDLE, aligned request (req_valid=1):
- Completes in one cycle, combinationally: mem_cs=0, mem_wr=~req_we, mem_mask=base<<o (stores only; 0 on loads), mem_wdata=req_wdata<<8o.
- done=1, stall=0.
- Load result: ld_data = extend((mem_rdata>>8o) truncated to size); LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.

IDLE, misaligned request (first half):
- Access word A with mask (base<<o)[3:0] and data req_wdata<<8o.
- Outputs this cycle: stall=1, done=0.
- Registered on the rising edge: lo = mem_rdata>>8o, word A+1, funct3, o, we, wdata. Next state SECOND.

SECOND (second half):
- Uses only the latched values; core inputs are ignored.
- Accesses word A+1 with mask base>>(4-o) and data wdata>>8(4-o).
- Load result: ld_data = extend((mem_rdata<<8(4-o)) | lo).
- done=1, stall=0, then return to IDLE.

Boundary conditions:
- Word-address wrap: word A = 2^ADDR_W-1 makes the second access go to word 0.
- req_addr bits above ADDR_W+1 are ignored.
- Reset asserted in SECOND aborts the second half; a first-half store byte write already done is not undone.
- req_valid=0 in IDLE: no access, done=0.

Optional Feature:
Macro: MISALIGN_TRAP_EN
- Defined: adds output port misalign_trap (1 bit). A misaligned request performs no memory access and gives misalign_trap=1, done=1, stall=0, ld_data=0. SECOND is never entered. misalign_trap is 0 at reset and for every other request.
- Undefined: no misalign_trap port; misaligned accesses are split as described under Behaviour.

Test Plan:
- Memory preset to 0xDEADBEEF. SW 0x11223344 @0x4, then LW @0x4 -> mem_mask=1111, mem_addr=1; LW returns 0x11223344 with done=1 in the same cycle, stall never asserted.
- SW 0xAABBCCDD @0x6 -> cycle 1: addr 1, mask 1100, wdata 0xCCDD0000, stall=1. Cycle 2: addr 2, mask 0011, wdata 0x0000AABB, done=1. Memory words become 0xCCDDBEEF and 0xDEADAABB.
- Following that store, LW @0x6 -> 0xAABBCCDD after 2 cycles. LB @0x7 -> 0xFFFFFFCC; LBU @0x7 -> 0x000000CC.
- LH @0x7 (o=3, split) -> 0xFFFFBBCC; LHU @0x7 -> 0x0000BBCC.
- Wrap case: LW @0x007FFFFE -> first access word 0x1FFFFF, second access word 0x000000. Illegal funct3=011 -> done=1, mem_cs stays 1.
- Reset case: rst=1 during SECOND of a misaligned SW -> next cycle state IDLE, mem_cs=1, stall=0, second word unchanged. With MISALIGN_TRAP_EN, LW @0x2 -> misalign_trap=1, no memory access.

Source files
------------

// File: rtl/lsu_align_unit.sv
// lsu_align_unit: RV32I load/store alignment with two-cycle split of misaligned accesses.
// Optional macro MISALIGN_TRAP_EN: misaligned requests trap instead of being split.
module lsu_align_unit #(
    parameter int ADDR_W = 21
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       ld_data,
    output logic              mem_cs,
    output logic              mem_wr,
    output logic [3:0]        mem_mask,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              misalign_trap
`endif
);
    typedef enum logic {IDLE, SECOND} state_t;

    state_t            state_q, state_d;
    logic [31:0]       lo_q, lo_d, wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr2_q, addr2_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic              we_q, we_d;
    logic [1:0]        off, rem;
    logic [ADDR_W-1:0] word_a;
    logic [4:0]        sh_a, sh_b;
    logic              illegal, mis;

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
        case (f3)
            3'b000:  return {{24{v[7]}}, v[7:0]};
            3'b001:  return {{16{v[15]}}, v[15:0]};
            3'b010:  return v;
            3'b100:  return {24'd0, v[7:0]};
            3'b101:  return {16'd0, v[15:0]};
            default: return '0;
        endcase
    endfunction

    function automatic logic [3:0] base_mask(input logic [2:0] f3);
        return f3[1:0] == 2'b00 ? 4'b0001 : f3[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
    endfunction

    // Decode the request, drive the memory port and compute next state / latched halves
    always_comb begin
        off       = req_addr[1:0];
        word_a    = req_addr[ADDR_W+1:2];
        sh_a      = {off, 3'b000};
        rem       = 2'd0 - off_q;
        sh_b      = {rem, 3'b000};
        illegal   = req_funct3[1:0] == 2'b11 || req_funct3 == 3'b110 || (req_we && req_funct3[2]);
        mis       = (req_funct3[1:0] == 2'b01 && off == 2'd3) || (req_funct3[1:0] == 2'b10 && off != 2'd0);
        state_d   = state_q;
        lo_d      = lo_q;
        wdata_d   = wdata_q;
        addr2_d   = addr2_q;
        f3_d      = f3_q;
        off_d     = off_q;
        we_d      = we_q;
        stall     = 1'b0;
        done      = 1'b0;
        ld_data   = '0;
        mem_cs    = 1'b1;
        mem_wr    = 1'b1;
        mem_mask  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
`ifdef MISALIGN_TRAP_EN
        misalign_trap = 1'b0;
`endif
        if (!rst) begin
            if (state_q == SECOND) begin
                mem_cs    = 1'b0;
                mem_wr    = ~we_q;
                mem_addr  = addr2_q;
                mem_wdata = wdata_q >> sh_b;
                mem_mask  = we_q ? base_mask(f3_q) >> {1'b0, rem} : 4'b0000;
                ld_data   = we_q ? 32'd0 : extend(f3_q, (mem_rdata << sh_b) | lo_q);
                done      = 1'b1;
                state_d   = IDLE;
            end else if (req_valid) begin
                if (illegal) begin
                    done = 1'b1;
`ifdef MISALIGN_TRAP_EN
                end else if (mis) begin
                    misalign_trap = 1'b1;
                    done          = 1'b1;
`endif
                end else begin
                    mem_cs    = 1'b0;
                    mem_wr    = ~req_we;
                    mem_addr  = word_a;
                    mem_wdata = req_wdata << sh_a;
                    mem_mask  = req_we ? base_mask(req_funct3) << off : 4'b0000;
                    if (mis) begin
                        stall   = 1'b1;
                        state_d = SECOND;
                        lo_d    = mem_rdata >> sh_a;
                        addr2_d = word_a + ADDR_W'(1);
                        f3_d    = req_funct3;
                        off_d   = off;
                        we_d    = req_we;
                        wdata_d = req_wdata;
                    end else begin
                        done    = 1'b1;
                        ld_data = req_we ? 32'd0 : extend(req_funct3, mem_rdata >> sh_a);
                    end
                end
            end
        end
    end

    // State and first-half capture registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lo_q    <= '0;
            wdata_q <= '0;
            addr2_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            wdata_q <= wdata_d;
            addr2_q <= addr2_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            we_q    <= we_d;
        end
    end
endmodule

// File: tb/tb_lsu_align_unit.sv
// tb_lsu_align_unit: directed checks of lsu_align_unit against a small byte-masked memory model.
module tb_lsu_align_unit;
    logic        clk = 1'b0;
    logic        rst, req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, mem_cs, mem_wr;
    logic [31:0] ld_data, mem_wdata, mem_rdata;
    logic [3:0]  mem_mask;
    logic [20:0] mem_addr;
    logic [31:0] m [8];
    int          total = 0;
    int          bad = 0;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    lsu_align_unit #(.ADDR_W(21)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .ld_data(ld_data), .mem_cs(mem_cs),
        .mem_wr(mem_wr), .mem_mask(mem_mask), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MISALIGN_TRAP_EN
        , .misalign_trap(misalign_trap)
`endif
    );

    always #5 clk = ~clk;

    // Word 0x1FFFFF aliases onto entry 7 of the eight-entry model
    assign mem_rdata = m[mem_addr[2:0]];

    // Memory writes on the falling edge with byte enables
    always @(negedge clk) begin
        if (!mem_cs && !mem_wr)
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) m[mem_addr[2:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic v, input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        req_valid  = v;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        #2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m[i] = 32'hDEADBEEF;
        rst = 1'b1;
        req(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
        step();
        #2;
        chk("rst_cs", {31'd0, mem_cs}, 32'd1);
        chk("rst_wr", {31'd0, mem_wr}, 32'd1);
        chk("rst_stall_done", {30'd0, stall, done}, 32'd0);
        chk("rst_mask", {28'd0, mem_mask}, 32'd0);
        chk("rst_addr", {11'd0, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_ld", ld_data, 32'd0);
        step();
        rst = 1'b0;
        req(1'b0, 1'b0, 3'b010, 32'h4, 32'h0);
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_cs", {31'd0, mem_cs}, 32'd1);
        // misaligned SW @6
        step();
        req(1'b1, 1'b1, 3'b010, 32'h6, 32'hAABBCCDD);
        chk("sw6_a_addr", {11'd0, mem_addr}, 32'd1);
        chk("sw6_a_mask", {28'd0, mem_mask}, 32'hC);
        chk("sw6_a_wdata", mem_wdata, 32'hCCDD0000);
        chk("sw6_a_ctl", {28'd0, stall, done, mem_cs, mem_wr}, 32'b1000);
        step();
        req(1'b1, 1'b0, 3'b000, 32'h40, 32'h0);
        chk("sw6_b_addr", {11'd0, mem_addr}, 32'd2);
        chk("sw6_b_mask", {28'd0, mem_mask}, 32'h3);
        chk("sw6_b_wdata", mem_wdata, 32'h0000AABB);
        chk("sw6_b_ctl", {28'd0, stall, done, mem_cs, mem_wr}, 32'b0100);
        step();
        req(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        chk("mem1_after_sw6", m[1], 32'hCCDDBEEF);
        chk("mem2_after_sw6", m[2], 32'hDEADAABB);
        // misaligned LW @6
        step();
        req(1'b1, 1'b0, 3'b010, 32'h6, 32'h0);
        chk("lw6_a_stall", {30'd0, stall, done}, 32'b10);
        step();
        chk("lw6_b_ld", ld_data, 32'hAABBCCDD);
        chk("lw6_b_done", {30'd0, stall, done}, 32'b01);
        step();
        req(1'b1, 1'b0, 3'b000, 32'h7, 32'h0);
        chk("lb7", ld_data, 32'hFFFFFFCC);
        chk("lb7_done", {30'd0, stall, done}, 32'b01);
        step();
        req(1'b1, 1'b0, 3'b100, 32'h7, 32'h0);
        chk("lbu7", ld_data, 32'h000000CC);
        // LH/LHU @7 split
        step();
        req(1'b1, 1'b0, 3'b001, 32'h7, 32'h0);
        chk("lh7_a_stall", {30'd0, stall, done}, 32'b10);
        step();
        chk("lh7_b_ld", ld_data, 32'hFFFFBBCC);
        step();
        req(1'b1, 1'b0, 3'b101, 32'h7, 32'h0);
        step();
        chk("lhu7_b_ld", ld_data, 32'h0000BBCC);
        // aligned SW/LW @4
        step();
        req(1'b1, 1'b1, 3'b010, 32'h4, 32'h11223344);
        chk("sw4_mask", {28'd0, mem_mask}, 32'hF);
        chk("sw4_addr", {11'd0, mem_addr}, 32'd1);
        chk("sw4_ctl", {28'd0, stall, done, mem_cs, mem_wr}, 32'b0100);
        step();
        req(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
        chk("lw4_ld", ld_data, 32'h11223344);
        chk("lw4_done", {30'd0, stall, done}, 32'b01);
        // upper address bits ignored
        step();
        req(1'b1, 1'b0, 3'b010, 32'hFF000004, 32'h0);
        chk("hi_addr", {11'd0, mem_addr}, 32'd1);
        chk("hi_ld", ld_data, 32'h11223344);
        // aligned SH @9
        step();
        req(1'b1, 1'b1, 3'b001, 32'h9, 32'h12345678);
        chk("sh9_mask", {28'd0, mem_mask}, 32'h6);
        chk("sh9_wdata", mem_wdata, 32'h34567800);
        step();
        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        chk("mem2_after_sh9", m[2], 32'hDE5678BB);
        // word-address wrap
        step();
        req(1'b1, 1'b0, 3'b010, 32'h007FFFFE, 32'h0);
        chk("wrap_a_addr", {11'd0, mem_addr}, 32'h1FFFFF);
        step();
        chk("wrap_b_addr", {11'd0, mem_addr}, 32'h0);
        chk("wrap_b_ld", ld_data, 32'hBEEFDEAD);
        // illegal funct3
        step();
        req(1'b1, 1'b0, 3'b011, 32'h4, 32'h0);
        chk("ill_ctl", {29'd0, stall, done, mem_cs}, 32'b011);
        chk("ill_ld", ld_data, 32'd0);
        step();
        req(1'b1, 1'b1, 3'b100, 32'h4, 32'h0);
        chk("ill_store_ctl", {29'd0, stall, done, mem_cs}, 32'b011);
        // reset during SECOND of misaligned SW @0xE
        step();
        req(1'b1, 1'b1, 3'b010, 32'hE, 32'hCAFEF00D);
        chk("rsw_a_stall", {31'd0, stall}, 32'd1);
        step();
        rst = 1'b1;
        #2;
        chk("rsw_rst_ctl", {29'd0, stall, done, mem_cs}, 32'b001);
        step();
        rst = 1'b0;
        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        chk("rsw_idle_ctl", {29'd0, stall, done, mem_cs}, 32'b001);
        chk("rsw_mem3", m[3], 32'hF00DBEEF);
        chk("rsw_mem4", m[4], 32'hDEADBEEF);
`ifdef MISALIGN_TRAP_EN
        step();
        req(1'b1, 1'b0, 3'b010, 32'h2, 32'h0);
        chk("trap_ctl", {28'd0, misalign_trap, stall, done, mem_cs}, 32'b1011);
        chk("trap_ld", ld_data, 32'd0);
`endif
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
